w_schedule_expand: RTL and testbench

- Downstream of the first-16-word loader. It takes W[0..15] when that loader raises its w_16_complete flag.
- It expands W[16..63] on the fly and streams all 64 schedule words, one per cycle, to the compression round logic.
- It uses a 16-word sliding window instead of a 2048-bit register, with a valid/ready handshake on the output.

---
 rtl/sha256_pkg.sv | 33 +++
 rtl/w_next_word.sv | 20 ++
 rtl/w_schedule_expand.sv | 88 ++++++++
 tb/tb_w_schedule_expand.sv | 280 ++++++++++++++++++++++++++++
 4 files changed

// File: rtl/sha256_pkg.sv
`default_nettype none
// ============================================================================
// Package  : sha256_pkg
// Brief    : Shared SHA-256 schedule constants, types and sigma functions.
// Revision : 1.0
// ============================================================================
package sha256_pkg;

    localparam int WORD_WIDTH = 32;
    localparam int W_LENGTH   = 64;
    localparam int WIN_DEPTH  = 16;
    localparam int IDX_WIDTH  = $clog2(W_LENGTH);

    typedef logic [WORD_WIDTH-1:0] word_t;

    typedef enum logic [1:0] {
        IDLE   = 2'd0,
        STREAM = 2'd1,
        DONE   = 2'd2
    } state_t;

    // ROTR7 ^ ROTR18 ^ SHR3
    function automatic word_t sha_sigma0(input word_t x);
        return {x[6:0], x[31:7]} ^ {x[17:0], x[31:18]} ^ (x >> 3);
    endfunction

    // ROTR17 ^ ROTR19 ^ SHR10
    function automatic word_t sha_sigma1(input word_t x);
        return {x[16:0], x[31:17]} ^ {x[18:0], x[31:19]} ^ (x >> 10);
    endfunction

endpackage
`default_nettype wire

// File: rtl/w_next_word.sv
`default_nettype none
// ============================================================================
// Module   : w_next_word
// Brief    : Combinational W[t+16] from the sliding-window taps.
// Revision : 1.0
// ============================================================================
module w_next_word
    import sha256_pkg::*;
(
    input  logic [WORD_WIDTH-1:0] i_win_14,
    input  logic [WORD_WIDTH-1:0] i_win_9,
    input  logic [WORD_WIDTH-1:0] i_win_1,
    input  logic [WORD_WIDTH-1:0] i_win_0,
    output logic [WORD_WIDTH-1:0] o_next
);

    assign o_next = sha_sigma1(i_win_14) + i_win_9 + sha_sigma0(i_win_1) + i_win_0;

endmodule
`default_nettype wire

// File: rtl/w_schedule_expand.sv
`default_nettype none
// ============================================================================
// Module   : w_schedule_expand
// Brief    : Streams W[0..63] one per cycle from a 16-word sliding window,
//            expanding W[16..63] on the fly behind a valid/ready handshake.
// Revision : 1.0
// ============================================================================
module w_schedule_expand
    import sha256_pkg::*;
(
    input  logic                            clock,
    input  logic                            reset,
    input  logic                            enable,
    input  logic                            start,
    input  logic [WIN_DEPTH*WORD_WIDTH-1:0] w16_vector,
    input  logic                            out_ready,
    output logic                            w_valid,
    output logic [WORD_WIDTH-1:0]           w_word,
    output logic [IDX_WIDTH-1:0]            w_index,
    output logic                            w_done,
    output logic                            busy
);

    localparam logic [IDX_WIDTH-1:0] c_T_LAST   = IDX_WIDTH'(W_LENGTH - 1);
    localparam logic [IDX_WIDTH-1:0] c_T_EXPAND = IDX_WIDTH'(W_LENGTH - WIN_DEPTH - 1);

    state_t               r_state;
    state_t               w_state_nxt;
    word_t                r_win [WIN_DEPTH];
    logic [IDX_WIDTH-1:0] r_t;
    word_t                w_next;
    logic                 w_load;
    logic                 w_accept;

    assign w_load   = (r_state == IDLE) && enable && start;
    assign w_accept = (r_state == STREAM) && out_ready;

    w_next_word u_next_word (
        .i_win_14 (r_win[14]),
        .i_win_9  (r_win[9]),
        .i_win_1  (r_win[1]),
        .i_win_0  (r_win[0]),
        .o_next   (w_next)
    );

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            IDLE:    if (start) w_state_nxt = STREAM;
            STREAM:  if (w_accept && (r_t == c_T_LAST)) w_state_nxt = DONE;
            DONE:    w_state_nxt = IDLE;
            default: w_state_nxt = IDLE;
        endcase
        // Dropping enable abandons the stream from any state.
        if (!enable) w_state_nxt = IDLE;
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_ff @(posedge clock or posedge reset) begin
        if (reset) begin
            for (int i = 0; i < WIN_DEPTH; i++) r_win[i] <= '0;
            r_t <= '0;
        end else if (w_load) begin
            for (int i = 0; i < WIN_DEPTH; i++) r_win[i] <= w16_vector[WORD_WIDTH*i +: WORD_WIDTH];
            r_t <= '0;
        end else if (w_accept) begin
            for (int i = 0; i < WIN_DEPTH-1; i++) r_win[i] <= r_win[i+1];
            // Past W[63] the expansion has no meaning; fill with zero to stay deterministic.
            r_win[WIN_DEPTH-1] <= (r_t <= c_T_EXPAND) ? w_next : '0;
            if (r_t != c_T_LAST) r_t <= r_t + 1'b1;
        end
    end

    assign w_valid = (r_state == STREAM);
    assign busy    = (r_state == STREAM);
    assign w_done  = (r_state == DONE);
    assign w_word  = r_win[0];
    assign w_index = r_t;

endmodule
`default_nettype wire

// File: tb/tb_w_schedule_expand.sv
`default_nettype none
// ============================================================================
// Module   : tb_w_schedule_expand
// Brief    : Scoreboard bench for w_schedule_expand with a reference schedule model.
// Revision : 1.0
// ============================================================================
module tb_w_schedule_expand;

    logic         clock = 1'b0;
    logic         reset;
    logic         enable;
    logic         start;
    logic [511:0] w16_vector;
    logic         out_ready;
    logic         w_valid;
    logic [31:0]  w_word;
    logic [5:0]   w_index;
    logic         w_done;
    logic         busy;

    typedef struct packed {
        logic [5:0]  idx;
        logic [31:0] word;
    } exp_t;

    exp_t        exp_q[$];
    logic [31:0] ref_w [64];
    logic [31:0] got_w [64];
    int          n_checks = 0;
    int          n_fail   = 0;
    int          accepts  = 0;
    int          ready_mode = 0;

    w_schedule_expand dut (
        .clock      (clock),
        .reset      (reset),
        .enable     (enable),
        .start      (start),
        .w16_vector (w16_vector),
        .out_ready  (out_ready),
        .w_valid    (w_valid),
        .w_word     (w_word),
        .w_index    (w_index),
        .w_done     (w_done),
        .busy       (busy)
    );

    always #5 clock = ~clock;

    task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_checks++;
        if (act !== exp) begin
            n_fail++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    function automatic logic [31:0] rotr(input logic [31:0] x, input int n);
        return (x >> n) | (x << (32 - n));
    endfunction

    // Textbook schedule recurrence over the full 64-entry array.
    task automatic build_ref(input logic [511:0] v);
        logic [31:0] s0;
        logic [31:0] s1;
        for (int i = 0; i < 64; i++) begin
            if (i < 16) begin
                ref_w[i] = v[32*i +: 32];
            end else begin
                s0 = rotr(ref_w[i-15], 7) ^ rotr(ref_w[i-15], 18) ^ (ref_w[i-15] >> 3);
                s1 = rotr(ref_w[i-2], 17) ^ rotr(ref_w[i-2], 19) ^ (ref_w[i-2] >> 10);
                ref_w[i] = s1 + ref_w[i-7] + s0 + ref_w[i-16];
            end
        end
    endtask

    function automatic logic [511:0] rand_block();
        logic [511:0] v;
        for (int i = 0; i < 16; i++) v[32*i +: 32] = $urandom();
        return v;
    endfunction

    task automatic tick();
        @(posedge clock);
        #1;
    endtask

    // Issues start for one edge and queues the 64 expected words.
    task automatic launch(input logic [511:0] v);
        chk("queue_empty_before_start", 64'(exp_q.size()), 64'd0);
        w16_vector = v;
        start      = 1'b1;
        build_ref(v);
        for (int i = 0; i < 64; i++) exp_q.push_back({6'(i), ref_w[i]});
        accepts = 0;
        tick();
        start = 1'b0;
        chk("first_valid", 64'(w_valid), 64'd1);
        chk("first_index", 64'(w_index), 64'd0);
        chk("busy_after_start", 64'(busy), 64'd1);
    endtask

    task automatic wait_done(input int budget, input bit check_busy, output int cycles);
        cycles = 0;
        while (!w_done && cycles < budget) begin
            if (check_busy) chk("busy_held", 64'(busy), 64'd1);
            tick();
            cycles++;
        end
        chk("done_seen", 64'(w_done), 64'd1);
    endtask

    task automatic wait_index(input logic [5:0] idx);
        int n;
        n = 0;
        while (!(w_valid && w_index == idx) && n < 300) begin
            tick();
            n++;
        end
        chk("reach_index", 64'(w_valid && (w_index == idx)), 64'd1);
    endtask

    initial begin
        out_ready = 1'b1;
        forever begin
            @(posedge clock);
            #1;
            out_ready = (ready_mode == 0) ? 1'b1 : ($urandom_range(0, 1) == 1);
        end
    end

    // Monitor: pops the scoreboard on every accept and checks stall stability.
    initial begin : monitor
        exp_t        e;
        bit          holding;
        logic [31:0] hold_word;
        logic [5:0]  hold_idx;
        holding = 1'b0;
        forever begin
            @(negedge clock);
            if (holding) begin
                chk("stall_valid", 64'(w_valid), 64'd1);
                chk("stall_word", 64'(w_word), 64'(hold_word));
                chk("stall_index", 64'(w_index), 64'(hold_idx));
            end
            holding = 1'b0;
            if (w_done) chk("done_queue_empty", 64'(exp_q.size()), 64'd0);
            if (w_valid) begin
                if (!out_ready) begin
                    holding   = 1'b1;
                    hold_word = w_word;
                    hold_idx  = w_index;
                end else if (exp_q.size() == 0) begin
                    chk("unexpected_word", 64'(w_valid), 64'd0);
                end else begin
                    e = exp_q.pop_front();
                    chk("word", 64'(w_word), 64'(e.word));
                    chk("index", 64'(w_index), 64'(e.idx));
                    got_w[w_index] = w_word;
                    accepts++;
                end
            end
        end
    end

    initial begin
        #400000;
        $display("FAIL watchdog: simulation did not complete");
        $fatal(1);
    end

    initial begin
        logic [511:0] abc;
        int           cyc;

        reset      = 1'b1;
        enable     = 1'b0;
        start      = 1'b0;
        w16_vector = '0;
        #12;
        chk("reset_valid", 64'(w_valid), 64'd0);
        chk("reset_busy", 64'(busy), 64'd0);
        chk("reset_done", 64'(w_done), 64'd0);
        chk("reset_word", 64'(w_word), 64'd0);
        chk("reset_index", 64'(w_index), 64'd0);
        tick();
        reset  = 1'b0;
        enable = 1'b1;
        tick();
        chk("idle_valid", 64'(w_valid), 64'd0);

        // "abc" block, no backpressure
        abc = '0;
        abc[31:0]    = 32'h61626380;
        abc[511:480] = 32'h00000018;
        launch(abc);
        wait_done(200, 1'b0, cyc);
        chk("done_latency", 64'(cyc), 64'd64);
        chk("done_valid_low", 64'(w_valid), 64'd0);
        chk("done_busy_low", 64'(busy), 64'd0);
        chk("abc_accepts", 64'(accepts), 64'd64);
        chk("abc_w0", 64'(got_w[0]), 64'h61626380);
        chk("abc_w16", 64'(got_w[16]), 64'h61626380);
        chk("abc_w17", 64'(got_w[17]), 64'h000F0000);
        chk("abc_w18", 64'(got_w[18]), 64'h7DA86405);
        chk("abc_w63", 64'(got_w[63]), 64'h12B1EDEB);
        tick();
        chk("done_one_cycle", 64'(w_done), 64'd0);

        // Same block under random backpressure
        ready_mode = 1;
        launch(abc);
        wait_done(1000, 1'b0, cyc);
        chk("stall_accepts", 64'(accepts), 64'd64);
        chk("stall_w63", 64'(got_w[63]), 64'h12B1EDEB);
        ready_mode = 0;
        tick();

        // start re-asserted mid-stream is ignored
        launch(rand_block());
        wait_index(6'd20);
        start      = 1'b1;
        w16_vector = rand_block();
        tick();
        start = 1'b0;
        wait_done(200, 1'b1, cyc);
        chk("restart_ignored_accepts", 64'(accepts), 64'd64);
        tick();

        // enable drop at t = 30, then fresh block
        launch(rand_block());
        wait_index(6'd30);
        enable = 1'b0;
        tick();
        chk("abort_valid", 64'(w_valid), 64'd0);
        chk("abort_busy", 64'(busy), 64'd0);
        chk("abort_done", 64'(w_done), 64'd0);
        exp_q.delete();
        enable = 1'b1;
        tick();
        launch(rand_block());
        wait_done(200, 1'b0, cyc);
        chk("after_abort_latency", 64'(cyc), 64'd64);
        tick();

        // asynchronous reset at t = 40
        launch(rand_block());
        wait_index(6'd40);
        #2;
        reset = 1'b1;
        #1;
        chk("async_reset_valid", 64'(w_valid), 64'd0);
        chk("async_reset_busy", 64'(busy), 64'd0);
        chk("async_reset_done", 64'(w_done), 64'd0);
        chk("async_reset_index", 64'(w_index), 64'd0);
        exp_q.delete();
        tick();
        reset = 1'b0;
        tick();
        launch(rand_block());
        wait_done(200, 1'b0, cyc);
        chk("after_reset_latency", 64'(cyc), 64'd64);

        // back-to-back: start during DONE is not sampled, then zero block
        start      = 1'b1;
        w16_vector = '0;
        tick();
        chk("start_in_done_ignored", 64'(w_valid), 64'd0);
        launch('0);
        wait_done(200, 1'b0, cyc);
        chk("zero_block_latency", 64'(cyc), 64'd64);
        chk("zero_block_w63", 64'(got_w[63]), 64'd0);
        tick();

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
        $finish;
    end

endmodule
`default_nettype wire
